// File: rtl/data_mem_sized.sv
// Byte-addressed MEM-stage data memory: sized loads/stores with sign/zero extension, registered read,
// misalignment rejection and a zero-clear sweep after reset. Define DATA_MEM_BIG_ENDIAN_EN for big-endian lanes.
module data_mem_sized #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              Misaligned,
  output logic              Busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBW   = $clog2(NB);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH / NB - 1);
`ifdef DATA_MEM_BIG_ENDIAN_EN
  localparam bit BIG_END = 1'b1;
`else
  localparam bit BIG_END = 1'b0;
`endif

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] clrRow, clrRowNext;
  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] byteAddr, clrBase;
  logic [3:0]        nBytes;
  logic              misal, reqRead, reqAny, doWrite;
  logic [7:0]        wrBytes [NB];
  logic [DATA_W-1:0] rawRead;
  logic              unusedAddrHi;

  // Data-bus lane that carries byte offset idx of an n-byte access
  function automatic int lanePos(input int idx, input int n);
    return BIG_END ? (n - 1 - idx) : idx;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw, input int n,
                                               input logic uns);
    logic [DATA_W-1:0] res;
    logic              sgn;
    res = raw;
    sgn = 1'b0;
    for (int j = 0; j < NB; j++)
      if (j == n - 1) sgn = raw[8*j+7];
    for (int j = 0; j < NB; j++)
      if (j >= n) res[8*j +: 8] = {8{sgn & ~uns}};
    return res;
  endfunction

  assign byteAddr     = Address[ADDR_W-1:0];
  assign unusedAddrHi = ^Address[31:ADDR_W];
  assign clrBase      = clrRow << NBW;
  assign Busy         = (state == CLEAR);

  always_comb begin
    case (Size)
      2'b00:   nBytes = 4'd1;
      2'b01:   nBytes = 4'd2;
      2'b10:   nBytes = 4'd4;
      default: nBytes = 4'(NB);
    endcase
  end

  assign misal   = |(byteAddr & ADDR_W'(nBytes - 4'd1));
  assign reqRead = MemRead & ~Busy;
  assign reqAny  = (MemRead | MemWrite) & ~Busy;
  assign doWrite = MemWrite & ~Busy & ~misal;

  // Steer bytes between memory offsets and data-bus lanes
  always_comb begin
    rawRead = '0;
    for (int i = 0; i < NB; i++) begin
      wrBytes[i] = 8'h00;
      for (int j = 0; j < NB; j++) begin
        if (i < int'(nBytes) && j == lanePos(i, int'(nBytes))) begin
          wrBytes[i]        = WriteData[8*j +: 8];
          rawRead[8*j +: 8] = mem[byteAddr + ADDR_W'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLR_ON_RST) state <= CLEAR;
      else            state <= IDLE;
      clrRow <= '0;
    end else begin
      state  <= stateNext;
      clrRow <= clrRowNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrRowNext = clrRow;
    case (state)
      CLEAR: begin
        clrRowNext = clrRow + 1'b1;
        if (clrRow == LAST_ROW) begin
          stateNext  = IDLE;
          clrRowNext = '0;
        end
      end
      default: ;
    endcase
  end

  // Storage: the sweep owns the array while busy, otherwise aligned stores land here
  always_ff @(posedge clk) begin
    if (Busy) begin
      for (int i = 0; i < NB; i++) mem[clrBase + ADDR_W'(i)] <= 8'h00;
    end else if (doWrite) begin
      for (int i = 0; i < NB; i++)
        if (i < int'(nBytes)) mem[byteAddr + ADDR_W'(i)] <= wrBytes[i];
    end
  end

  // Output stage: read data reflects pre-write contents of the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      ReadValid  <= reqRead;
      Misaligned <= reqAny & misal;
      if (reqRead) ReadData <= misal ? '0 : extend(rawRead, int'(nBytes), Unsigned);
    end
  end
endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised successor to the single-port 32-bit data memory.
- Byte-addressed RAM with configurable width and depth.
- Supports byte, half, word and full-width accesses, with sign or zero extension on loads.
- Has a registered read port, detects misaligned accesses, and clears itself to zero after reset. Sits on the MEM stage of the datapath.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- ADDR_W, 8, byte-address bits actually decoded; capacity = 2^ADDR_W bytes.
- CLR_ON_RST, 1, 1 = run the zero-clear sweep after reset; 0 = skip it, go straight to IDLE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Address  in  32  byte address; bits above ADDR_W-1 are ignored.
- WriteData  in  DATA_W  store data, right-justified.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Size  in  2  00 byte, 01 half, 10 word(32), 11 full DATA_W.
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- ReadData  out  DATA_W  load result, registered.
- ReadValid  out  1  one-cycle pulse qualifying ReadData.
- Misaligned  out  1  one-cycle pulse marking a rejected access.
- Busy  out  1  high during the clear sweep; requests are ignored while high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ReadData=0, ReadValid=0, Misaligned=0.
  - Busy=1 if CLR_ON_RST else 0.
  - FSM goes to CLEAR (or IDLE), clear counter = 0.
- FSM states CLEAR and IDLE.
  - CLEAR: one DATA_W/8-byte row written to zero per cycle, counter increments.
  - After 2^ADDR_W/(DATA_W/8) cycles, go to IDLE and drop Busy on the same edge.
  - Reset asserted mid-sweep restarts the sweep from row 0.
- Request ignored when Busy=1: no write, ReadValid stays 0.
- Access byte count N = 1, 2, 4 or DATA_W/8 per Size.
- Alignment: misaligned when Address mod N != 0.
  - The write is suppressed.
  - On the next edge Misaligned=1 for one cycle.
  - If MemRead was set: ReadValid=1 and ReadData=0.
- Store: on the clk edge, byte lanes Address..Address+N-1 take WriteData[8N-1:0]. All other bytes are unchanged.
- Load latency is 1 cycle. Request at edge k gives ReadData/ReadValid valid after edge k, held until the next request.
  - Bytes are assembled from Address..Address+N-1.
  - Result is extended to DATA_W: sign from bit 8N-1 when Unsigned=0, zero-fill when Unsigned=1.
- MemRead and MemWrite in the same cycle, same address: the read returns pre-write contents (read-before-write); the write still happens.
- Write at edge k followed by a read at edge k+1 returns the new data.
- Size=11 with DATA_W=32 is identical to Size=10.
- Address wrap: only [ADDR_W-1:0] is decoded. 0x14141414 and 0x00000014 hit the same byte.
- ReadValid and Misaligned deassert the cycle after their pulse unless a new request arrives.

Optional Feature:
- Macro: DATA_MEM_BIG_ENDIAN_EN.
- Defined: byte Address holds the most-significant byte of a multi-byte access.
- Undefined (default): little-endian; byte Address holds the least-significant byte.
- Extension rules and alignment checks are identical in both modes.

Test Plan:
1. Reset release, DATA_W=32, ADDR_W=8 -> Busy=1 for exactly 64 cycles then 0. Load word at 0x00 -> ReadData=0x00000000, ReadValid pulse one cycle later.
2. Store word 0x99999999 at 0x14141414, then load word at 0x00000014 -> ReadData=0x99999999. Store word 0xEEEEEEEE at 0x28282828, load 0x28 -> 0xEEEEEEEE.
3. Clear row 0x28, store byte 0xAB at 0x29, load word 0x28 -> 0x0000AB00 (little-endian), 0x00AB0000 with DATA_MEM_BIG_ENDIAN_EN.
4. Store half 0x8001 at 0x30. Signed half load -> 0xFFFF8001; Unsigned=1 -> 0x00008001. Signed byte load at 0x30 -> 0x00000001, at 0x31 -> 0xFFFFFF80 (little-endian).
5. Store word 0x12345678 at 0x22 -> Misaligned pulse, word at 0x20 unchanged. Load half at 0x21 -> Misaligned=1, ReadValid=1, ReadData=0.
6. Assert rst_n low at sweep cycle 20, release -> Busy high a full 64 cycles again. Requests issued while Busy produce no ReadValid and no write.
